prog_mul_acc: RTL and testbench
===============================

# prog_mul_acc

Downstream accumulator for the progressive Q0.15 multiplier. Consumes one selected precision stream of signed products (Q1.6, Q1.14 or Q1.30), aligns each product to a common Q1.30 grid and sums VEC_LEN products into a wide accumulator. Each completed dot product is presented on a one-deep valid/ready output register, ready for the attention score/softmax stage. The block runs on the fast multiplier clock.

## Interface

- ACC_W, 40: accumulator width, signed, Q(ACC_W-31).30.
- OUT_W, 32: result width, signed Q1.30.
- VEC_LEN, 16: products per dot product, ≥1.
- clk  in  1  fast clock, same as the multiplier base clock.
- rst_n  in  1  reset, asynchronous, active-low.
- prec  in  2  precision select: 0=Q1.6, 1=Q1.14, 2=Q1.30, 3=reserved, treated as 2.
- clr  in  1  synchronous abort of the current vector.
- q1_6_in  in  8  Q1.6 product.
- q1_6_valid  in  1  product valid, held 1 cycle per product.
- q1_14_in  in  16  Q1.14 product.
- q1_14_valid  in  1  product valid, held 2 cycles per product.
- q1_30_in  in  32  Q1.30 product.
- q1_30_valid  in  1  product valid, held 4 cycles per product.
- out_data  out  OUT_W  dot-product result, Q1.30.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- overrun  out  1  sticky flag: a result was dropped. Cleared by clr.
- busy  out  1  high while in ACCUM.

## Operation

- **States:**
  - IDLE moves to ACCUM on the first accepted product.
  - ACCUM returns to IDLE when product VEC_LEN is accepted, or on clr.
- **Precision latch:** `prec` is sampled on the first product of a vector and held in `prec_q`. Changes mid-vector are ignored.
- **Product acceptance:**
  - A product is accepted when the valid for `prec_q` is high and the hold counter is 0. In IDLE, the live `prec` selects the valid instead.
  - On acceptance, the hold counter loads 0, 1 or 3 for Q1.6, Q1.14 or Q1.30. It then decrements every cycle.
  - Valids on the two non-selected streams are ignored.
- **Alignment:** each product is sign-extended to ACC_W and shifted left.
  - Q1.6: shift left 24.
  - Q1.14: shift left 16.
  - Q1.30: no shift.
- **Accumulation:**
  - On the first product, acc = aligned product. On later products, acc += aligned product.
  - Arithmetic is two's complement and wraps at ACC_W.
  - A counter runs 0..VEC_LEN-1. When the last product is accepted, the final sum (acc plus that product) goes to the output stage.
- **Output register:**
  - If out_valid=0, or out_ready=1 in the same cycle, load out_data and set out_valid.
  - Otherwise drop the result and set overrun.
  - out_valid clears on out_valid & out_ready when no new result loads.
- **clr:**
  - Returns the FSM to IDLE and zeroes acc, the counter and the hold counter. Clears overrun.
  - The output register is untouched. A product arriving with clr is discarded.
- **Reset values:** out_data=0, out_valid=0, overrun=0, busy=0, state IDLE, all counters 0.

## Timing

- out_valid rises 1 cycle after the clock edge that accepts the last product.
- Minimum spacing between accepted products: 1, 2 or 4 cycles for Q1.6, Q1.14 or Q1.30.
- Back-to-back vectors: the first product of the next vector may be accepted in the same cycle the previous result is written. There are no dead cycles.
- VEC_LEN=1: every accepted product yields a result the next cycle.
- Reset asserted mid-vector: all state clears immediately and the partial sum is lost.

## Configuration

- **ACC_SAT_EN defined:** the result is saturated to the signed OUT_W range, i.e. 0x7FFFFFFF / 0x80000000 for OUT_W=32.
- **ACC_SAT_EN undefined:** the result is acc[OUT_W-1:0], with wrap-around truncation.

## Structure

- **Package tva_acc_pkg:**
  - prec_e enum (PREC_Q1_6, PREC_Q1_14, PREC_Q1_30).
  - Shift constants: 24, 16, 0.
  - Hold constants: 0, 1, 3.
  - acc_state_e (IDLE, ACCUM).
- **Sub-module acc_align:** combinational select, sign-extend and shift of the three streams by precision.
- **Top level:** FSM, counters, accumulator and output register.

## Test plan

1. **Q1.6 sum:** prec=0, VEC_LEN=4, four products 0x20 (+0.5) on consecutive cycles → out_data=0x80000000 with ACC_SAT_EN undefined (wrap), 0x7FFFFFFF with ACC_SAT_EN defined. out_valid rises the cycle after the 4th product.
2. **Q1.14 mixed sign:** prec=1, products 0x2000 and 0xE000, each valid held 2 cycles → out_data=0x00000000. Exactly 2 products counted, not 4.
3. **Q1.30 mid-vector prec change:** prec=2, products 0x40000000 then 0xC0000000 (each valid held 4 cycles); switch prec to 0 after the first product → result 0. Q1.6 valids during the vector are ignored.
4. **Backpressure:** out_ready=0 with two vectors completed → first result held, overrun=1. After clr, overrun=0.
5. **clr mid-vector:** clr after 2 of 4 products, then 4 fresh products of 0x01 (Q1.6) → out_data=0x04000000.
6. **Reset mid-vector:** rst_n low after 2 of 4 products → outputs 0, busy=0. The next vector sums from zero.

Source files
------------

// File: rtl/prog_mul_acc_pkg.sv
// rtl/prog_mul_acc_pkg.sv - shared types and constants for the progressive-product accumulator
// Package tva_acc_pkg: precision encoding, per-precision alignment shifts and
// hold counts, accumulator FSM states and small decode helpers.
package tva_acc_pkg;

    typedef enum logic [1:0] {
        PREC_Q1_6  = 2'd0,
        PREC_Q1_14 = 2'd1,
        PREC_Q1_30 = 2'd2
    } prec_e;

    // Left shift that places each product on the common Q1.30 grid
    localparam int SHIFT_Q1_6  = 24;
    localparam int SHIFT_Q1_14 = 16;
    localparam int SHIFT_Q1_30 = 0;

    // Cycles a product stays valid beyond its first cycle
    localparam logic [1:0] HOLD_Q1_6  = 2'd0;
    localparam logic [1:0] HOLD_Q1_14 = 2'd1;
    localparam logic [1:0] HOLD_Q1_30 = 2'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_e;

    // The reserved encoding 3 behaves as Q1.30
    function automatic prec_e prec_decode(input logic [1:0] p);
        return (p == 2'd3) ? PREC_Q1_30 : prec_e'(p);
    endfunction

    function automatic logic [1:0] hold_of(input prec_e p);
        case (p)
            PREC_Q1_6:  return HOLD_Q1_6;
            PREC_Q1_14: return HOLD_Q1_14;
            default:    return HOLD_Q1_30;
        endcase
    endfunction

endpackage

// File: rtl/prog_mul_acc_if.sv
// rtl/prog_mul_acc_if.sv - product streams and result handshake of prog_mul_acc
// master: drives the three product streams and out_ready, receives the result.
// slave : the accumulator side.
interface prog_mul_acc_if #(
    parameter int OUT_W = 32
);
    logic [7:0]       q1_6_in;
    logic             q1_6_valid;
    logic [15:0]      q1_14_in;
    logic             q1_14_valid;
    logic [31:0]      q1_30_in;
    logic             q1_30_valid;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output q1_6_in, q1_6_valid, q1_14_in, q1_14_valid,
               q1_30_in, q1_30_valid, out_ready,
        input  out_data, out_valid
    );

    modport slave (
        input  q1_6_in, q1_6_valid, q1_14_in, q1_14_valid,
               q1_30_in, q1_30_valid, out_ready,
        output out_data, out_valid
    );
endinterface

// File: rtl/prog_mul_acc_align.sv
// rtl/prog_mul_acc_align.sv - stream select, sign-extend and Q1.30 alignment
// Ports: prec (selected precision), three product streams with valids,
//        sel_valid (valid of the selected stream), aligned (ACC_W product).
module acc_align
    import tva_acc_pkg::*;
#(
    parameter int ACC_W = 40
) (
    input  prec_e             prec,
    input  logic [7:0]        q1_6_in,
    input  logic              q1_6_valid,
    input  logic [15:0]       q1_14_in,
    input  logic              q1_14_valid,
    input  logic [31:0]       q1_30_in,
    input  logic              q1_30_valid,
    output logic              sel_valid,
    output logic [ACC_W-1:0]  aligned
);

    always_comb begin
        sel_valid = 1'b0;
        aligned   = '0;
        case (prec)
            PREC_Q1_6: begin
                sel_valid = q1_6_valid;
                aligned   = {{(ACC_W-8){q1_6_in[7]}}, q1_6_in} << SHIFT_Q1_6;
            end
            PREC_Q1_14: begin
                sel_valid = q1_14_valid;
                aligned   = {{(ACC_W-16){q1_14_in[15]}}, q1_14_in} << SHIFT_Q1_14;
            end
            default: begin
                sel_valid = q1_30_valid;
                aligned   = {{(ACC_W-32){q1_30_in[31]}}, q1_30_in} << SHIFT_Q1_30;
            end
        endcase
    end

endmodule

// File: rtl/prog_mul_acc.sv
// rtl/prog_mul_acc.sv - dot-product accumulator for progressive multiplier products
// Ports: clk, rst_n (async, active-low), prec (precision select), clr (sync
//        abort), overrun (sticky dropped-result flag), busy (vector in progress),
//        s (prog_mul_acc_if.slave: product streams and result handshake).
// Build option: ACC_SAT_EN saturates the result to the signed OUT_W range;
//        otherwise the low OUT_W accumulator bits are returned.
module prog_mul_acc
    import tva_acc_pkg::*;
#(
    parameter int ACC_W   = 40,
    parameter int OUT_W   = 32,
    parameter int VEC_LEN = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   prec,
    input  logic         clr,
    output logic         overrun,
    output logic         busy,
    prog_mul_acc_if.slave s
);

    localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

    acc_state_e             state, state_nxt;
    prec_e                  prec_q, eff_prec;
    logic [1:0]             hold_cnt;
    logic [CNT_W-1:0]       vec_cnt;
    logic [ACC_W-1:0]       acc, aligned, sum;
    logic [OUT_W-1:0]       result;
    logic                   sel_valid, accept, last;

    // Live prec picks the stream only until the first product latches it
    assign eff_prec = (state == IDLE) ? prec_decode(prec) : prec_q;

    acc_align #(.ACC_W(ACC_W)) u_align (
        .prec        (eff_prec),
        .q1_6_in     (s.q1_6_in),
        .q1_6_valid  (s.q1_6_valid),
        .q1_14_in    (s.q1_14_in),
        .q1_14_valid (s.q1_14_valid),
        .q1_30_in    (s.q1_30_in),
        .q1_30_valid (s.q1_30_valid),
        .sel_valid   (sel_valid),
        .aligned     (aligned)
    );

    // The hold counter skips the repeated cycles of a multi-cycle valid
    assign accept = sel_valid && (hold_cnt == 2'd0) && !clr;
    assign last   = (vec_cnt == CNT_W'(VEC_LEN - 1));
    // acc is zero in IDLE, but the first product replaces it explicitly
    assign sum    = (state == IDLE) ? aligned : acc + aligned;

`ifdef ACC_SAT_EN
    // In range when every bit above the result sign bit matches it
    always_comb begin
        result = sum[OUT_W-1:0];
        if (!((&sum[ACC_W-1:OUT_W-1]) || !(|sum[ACC_W-1:OUT_W-1])))
            result = sum[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                  : {1'b0, {(OUT_W-1){1'b1}}};
    end
`else
    assign result = sum[OUT_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state == ACCUM);
        case (state)
            IDLE:  if (accept && !last) state_nxt = ACCUM;
            ACCUM: if (clr || (accept && last)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            vec_cnt  <= '0;
            hold_cnt <= 2'd0;
            prec_q   <= PREC_Q1_6;
        end else if (clr) begin
            acc      <= '0;
            vec_cnt  <= '0;
            hold_cnt <= 2'd0;
        end else begin
            if (accept)
                hold_cnt <= hold_of(eff_prec);
            else if (hold_cnt != 2'd0)
                hold_cnt <= hold_cnt - 2'd1;
            if (accept) begin
                if (state == IDLE) prec_q <= eff_prec;
                if (last) begin
                    acc     <= '0;
                    vec_cnt <= '0;
                end else begin
                    acc     <= sum;
                    vec_cnt <= vec_cnt + CNT_W'(1);
                end
            end
        end
    end

    // One-deep result register; a result arriving while it is full and not
    // being drained is dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s.out_data  <= '0;
            s.out_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (accept && last) begin
                if (!s.out_valid || s.out_ready) begin
                    s.out_data  <= result;
                    s.out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (s.out_valid && s.out_ready) begin
                s.out_valid <= 1'b0;
            end
            if (clr) overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prog_mul_acc.sv
// tb/tb_prog_mul_acc.sv - randomized and directed bench for prog_mul_acc against a value model
module tb_prog_mul_acc;
    import tva_acc_pkg::*;

    localparam int VEC = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic [1:0] prec;
    logic       overrun;
    logic       busy;

    always #5 clk = ~clk;

    prog_mul_acc_if #(.OUT_W(32)) bus ();

    prog_mul_acc #(.ACC_W(40), .OUT_W(32), .VEC_LEN(VEC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .prec    (prec),
        .clr     (clr),
        .overrun (overrun),
        .busy    (busy),
        .s       (bus.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: real-valued dot product on the Q1.30 grid
    int           m_cnt  = 0;
    int           m_prec = 0;
    longint       m_sum  = 0;
    logic [31:0]  exp_q[$];

    function automatic int map_prec(input logic [1:0] p);
        return (p == 2'd3) ? 2 : int'(p);
    endfunction

    function automatic logic [31:0] expected(input longint sum);
        logic signed [39:0] w;
        longint             ws;
        w  = sum[39:0];
        ws = longint'(w);
`ifdef ACC_SAT_EN
        if (ws > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (ws < -64'sd2147483648) return 32'h8000_0000;
`endif
        return ws[31:0];
    endfunction

    task automatic model_product(input int st, input logic [31:0] v);
        int     eff;
        longint val;
        eff = (m_cnt == 0) ? map_prec(prec) : m_prec;
        if (st != eff) return;
        case (st)
            0:       val = longint'($signed(v[7:0]))  * 64'sd16777216;
            1:       val = longint'($signed(v[15:0])) * 64'sd65536;
            default: val = longint'($signed(v));
        endcase
        if (m_cnt == 0) m_prec = eff;
        m_sum += val;
        m_cnt++;
        if (m_cnt == VEC) begin
            exp_q.push_back(expected(m_sum));
            m_cnt = 0;
            m_sum = 0;
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_sum = 0;
    endtask

    // Drive one product on stream st for its full 1/2/4-cycle window
    task automatic send(input int st, input logic [31:0] v);
        model_product(st, v);
        case (st)
            0:       begin bus.q1_6_in  = v[7:0];  bus.q1_6_valid  = 1'b1; end
            1:       begin bus.q1_14_in = v[15:0]; bus.q1_14_valid = 1'b1; end
            default: begin bus.q1_30_in = v;       bus.q1_30_valid = 1'b1; end
        endcase
        repeat (1 << st) @(negedge clk);
        case (st)
            0:       bus.q1_6_valid  = 1'b0;
            1:       bus.q1_14_valid = 1'b0;
            default: bus.q1_30_valid = 1'b0;
        endcase
    endtask

    // Scoreboard: every handshake must match the oldest expected result
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n === 1'b1 && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("spurious_out", 64'(exp_q.size()), 64'd1);
                else                   check("out_data", 64'(bus.out_data), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        logic [31:0] t1_exp;
        int          st;
        rst_n = 1'b0; clr = 1'b0; prec = 2'd0;
        bus.q1_6_in = '0;  bus.q1_6_valid = 1'b0;
        bus.q1_14_in = '0; bus.q1_14_valid = 1'b0;
        bus.q1_30_in = '0; bus.q1_30_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Q1.6: four +0.5 products sum to 2.0
`ifdef ACC_SAT_EN
        t1_exp = 32'h7FFF_FFFF;
`else
        t1_exp = 32'h8000_0000;
`endif
        prec = 2'd0;
        send(0, 32'h20);
        send(0, 32'h20);
        #1 check("t1_busy_mid", 64'(busy), 64'd1);
        send(0, 32'h20);
        send(0, 32'h20);
        #1;
        check("t1_valid_latency", 64'(bus.out_valid), 64'd1);
        check("t1_sum", 64'(bus.out_data), 64'(t1_exp));
        check("t1_busy_done", 64'(busy), 64'd0);

        // Q1.14: each 2-cycle valid counts once
        prec = 2'd1;
        send(1, 32'h2000);
        send(1, 32'hE000);
        #1 check("t2_busy_after2", 64'(busy), 64'd1);
        send(1, 32'h4000);
        send(1, 32'h0100);
        #1 check("t2_sum", 64'(bus.out_data), 64'h4100_0000);

        // Q1.30 with prec switched mid-vector and Q1.6 noise present
        bus.q1_6_in = 8'h7F; bus.q1_6_valid = 1'b1;
        prec = 2'd2;
        send(2, 32'h4000_0000);
        prec = 2'd0;
        send(2, 32'hC000_0000);
        bus.q1_6_valid = 1'b0;
        #1 check("t3_busy_after2", 64'(busy), 64'd1);
        send(2, 32'h1000_0000);
        send(2, 32'h0000_0001);
        #1 check("t3_sum", 64'(bus.out_data), 64'h1000_0001);
        prec = 2'd0;
        @(negedge clk);

        // Backpressure: second result is dropped, overrun sticks until clr
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2 * VEC; i++) send(0, 32'($urandom_range(0, 255)));
        #1;
        check("bp_qsize", 64'(exp_q.size()), 64'd2);
        check("bp_valid", 64'(bus.out_valid), 64'd1);
        check("bp_overrun", 64'(overrun), 64'd1);
        check("bp_held", 64'(bus.out_data), 64'(exp_q[0]));
        if (exp_q.size() > 1) exp_q.delete(1);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_drained", 64'(bus.out_valid), 64'd0);
        check("bp_overrun_sticky", 64'(overrun), 64'd1);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1 check("bp_overrun_clr", 64'(overrun), 64'd0);

        // clr mid-vector, then a fresh vector from zero
        @(negedge clk);
        send(0, 32'h55);
        send(0, 32'h33);
        clr = 1'b1;
        model_reset();
        @(negedge clk);
        clr = 1'b0;
        #1 check("t5_busy_clr", 64'(busy), 64'd0);
        for (int i = 0; i < VEC; i++) send(0, 32'h01);
        #1 check("t5_sum", 64'(bus.out_data), 64'h0400_0000);

        // Reset mid-vector
        repeat (2) @(negedge clk);
        send(0, 32'h11);
        send(0, 32'h22);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_out_data", 64'(bus.out_data), 64'd0);
        check("t6_out_valid", 64'(bus.out_valid), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < VEC; i++) send(0, 32'($urandom_range(0, 255)));

        // Random vectors: random precision, values, gaps and live prec changes
        for (int v = 0; v < 30; v++) begin
            prec = 2'($urandom_range(0, 3));
            st   = map_prec(prec);
            for (int p = 0; p < VEC; p++) begin
                if (p > 0 && $urandom_range(0, 3) == 0) prec = 2'($urandom_range(0, 3));
                send(st, $urandom());
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("drain", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
